// File: rtl/async_fifo_wptr_full.sv
// Write-domain controller for an asynchronous FIFO. It owns the binary and Gray write pointers,
// synchronises the read pointer into wclk, and produces full, almost-full, level and overflow status.
module async_fifo_wptr_full #(
  parameter int DSIZE       = 8,
  parameter int ASIZE       = 4,
  parameter int AFULL_LEVEL = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic               wclk,
  input  logic               wrst,
  input  logic               winc,
  input  logic [DSIZE-1:0]   wdata,
  input  logic               woverflow_clr,
  input  logic [ASIZE:0]     rptr_gray,
  output logic               wen,
  output logic [ASIZE-1:0]   waddr,
  output logic [DSIZE-1:0]   wmem_data,
  output logic [ASIZE:0]     wptr_gray,
  output logic               wfull,
  output logic               walmost_full,
  output logic [ASIZE:0]     wlevel,
  output logic               woverflow
);

  localparam logic [ASIZE:0] AFULL_THR = (ASIZE+1)'(AFULL_LEVEL);

  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [SYNC_STAGES-1:0][ASIZE:0] sync_r;
  logic [ASIZE:0] rq_s;
  logic [ASIZE:0] rbin_s;
  logic [ASIZE:0] wbin_r;
  logic [ASIZE:0] wbin_next_s;
  logic [ASIZE:0] wgray_next_s;
  logic [ASIZE:0] wlevel_next_s;
  logic [ASIZE:0] full_cmp_s;
  logic [ASIZE:0] wptr_gray_r;
  logic [ASIZE:0] wlevel_r;
  logic           wen_s;
  logic           wfull_next_s;
  logic           walmost_full_next_s;
  logic           wfull_r;
  logic           walmost_full_r;
  logic           woverflow_r;

  // Read-pointer synchroniser chain into the write clock domain
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], rptr_gray};
    end
  end

  // Next-state pointer and status computation; the gating on wrst drops a write in flight at reset
  always_comb begin
    rq_s                = sync_r[SYNC_STAGES-1];
    rbin_s              = gray2bin(rq_s);
    wen_s               = winc & ~wfull_r & ~wrst;
    wbin_next_s         = wbin_r + {{ASIZE{1'b0}}, wen_s};
    wgray_next_s        = bin2gray(wbin_next_s);
    full_cmp_s          = {~rq_s[ASIZE:ASIZE-1], rq_s[ASIZE-2:0]};
    wfull_next_s        = (wgray_next_s == full_cmp_s);
    wlevel_next_s       = wbin_next_s - rbin_s;
    walmost_full_next_s = (wlevel_next_s >= AFULL_THR);
  end

  // Pointer and status registers
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_r         <= '0;
      wptr_gray_r    <= '0;
      wfull_r        <= 1'b0;
      walmost_full_r <= 1'b0;
      wlevel_r       <= '0;
    end else begin
      wbin_r         <= wbin_next_s;
      wptr_gray_r    <= wgray_next_s;
      wfull_r        <= wfull_next_s;
      walmost_full_r <= walmost_full_next_s;
      wlevel_r       <= wlevel_next_s;
    end
  end

  // Sticky overflow: a rejected write takes priority over a clear on the same edge
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      woverflow_r <= 1'b0;
    end else if (winc && wfull_r) begin
      woverflow_r <= 1'b1;
    end else if (woverflow_clr) begin
      woverflow_r <= 1'b0;
    end else begin
      woverflow_r <= woverflow_r;
    end
  end

  assign wen          = wen_s;
  assign waddr        = wbin_r[ASIZE-1:0];
  assign wmem_data    = wdata;
  assign wptr_gray    = wptr_gray_r;
  assign wfull        = wfull_r;
  assign walmost_full = walmost_full_r;
  assign wlevel       = wlevel_r;
  assign woverflow    = woverflow_r;

endmodule
